// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: start/data/result bundle for the iterative AES-128 inverse cipher
interface aes_inv_cipher_iter_if;
    logic start;
    logic [0:127] ct;
    logic [0:127] key_last;
    logic busy;
    logic done;
    logic [0:127] pt;
    modport master (output start, ct, key_last, input busy, done, pt);
    modport slave (input start, ct, key_last, output busy, done, pt);
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: AES-128 inverse cipher, one round per clock, round keys unrolled backwards from key_last
module aes_inv_cipher_iter (
    input logic clk,
    input logic rst,
    aes_inv_cipher_iter_if.slave bus
);
    typedef enum logic {IDLE, RUN} fsm_t;
    localparam logic [7:0] RCON [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [7:0] IMC [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    fsm_t fsm;
    logic [0:127] state, rkey, next_key, next_state;
    logic [3:0] rnd;
    logic [31:0] k0, k1, k2, k3, p3, sw;
    logic [7:0] ak [16];
    logic [7:0] mix;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ t : p;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8), built from the squares x^2..x^128; maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] t = gmul(x, x);
        logic [7:0] r = t;
        for (int i = 0; i < 6; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = ginv(x);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    assign {k0, k1, k2, k3} = rkey;
    assign p3 = k3 ^ k2;
    assign sw = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
    assign next_key = {k0 ^ sw ^ {RCON[rnd + 4'd1], 24'h0}, k1 ^ k0, k2 ^ k1, p3};

    // byte i sits at row i%4, column i/4; InvShiftRows moves row r right by r columns
    always_comb begin
        next_state = '0;
        mix = 8'h00;
        for (int i = 0; i < 16; i++)
            ak[i] = inv_sbox(state[8 * (4 * ((i / 4 + 4 - i % 4) % 4) + i % 4) +: 8]) ^ next_key[8 * i +: 8];
        for (int i = 0; i < 16; i++) begin
            mix = 8'h00;
            for (int j = 0; j < 4; j++)
                mix = mix ^ gmul(ak[4 * (i / 4) + j], IMC[(j - i % 4 + 4) % 4]);
            next_state[8 * i +: 8] = (rnd == 4'd0) ? ak[i] : mix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            state <= '0;
            rkey <= '0;
            rnd <= 4'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pt <= '0;
        end else begin
            bus.done <= 1'b0;
            if (fsm == IDLE) begin
                if (bus.start) begin
                    state <= bus.ct ^ bus.key_last;
                    rkey <= bus.key_last;
                    rnd <= 4'd9;
                    bus.busy <= 1'b1;
                    fsm <= RUN;
                end
            end else begin
                state <= next_state;
                rkey <= next_key;
                if (rnd == 4'd0) begin
                    bus.pt <= next_state;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    fsm <= IDLE;
                end else begin
                    rnd <= rnd - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: FIPS-197 vectors plus random blocks produced by a forward AES-128 encryption model
module tb_aes_inv_cipher_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    aes_inv_cipher_iter_if bus();
    aes_inv_cipher_iter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic [0:127] kl;
        logic [0:127] ct;
        logic [0:127] pt;
    } vec_t;
    vec_t vecs [$];
    logic [7:0] sbox_t [256];

    localparam logic [0:127] KB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] KC = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [0:127] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PC = 128'h00112233445566778899aabbccddeeff;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force multiplicative inverse, then the affine map bit by bit
    function automatic logic [7:0] sb_calc(input int x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic encrypt(input logic [0:127] key, input logic [0:127] p, output logic [0:127] c, output logic [0:127] kl);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[32 * i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[8 * i +: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[4 * ((i / 4 + i % 4) % 4) + i % 4]];
            for (int cc = 0; cc < 4; cc++)
                for (int q = 0; q < 4; q++)
                    s[4 * cc + q] = (r < 10) ? xt(t[4 * cc + q]) ^ xt(t[4 * cc + (q + 1) % 4]) ^ t[4 * cc + (q + 1) % 4]
                                             ^ t[4 * cc + (q + 2) % 4] ^ t[4 * cc + (q + 3) % 4]
                                             : t[4 * cc + q];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) c[8 * i +: 8] = s[i];
        kl = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [0:127] kl, input logic [0:127] ct);
        bus.key_last = kl;
        bus.ct = ct;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ct = rand128();
        bus.key_last = rand128();
    endtask

    // n counts rising edges from the accepting edge (inclusive) to the edge that raised done
    task automatic wait_done(input string name, output int n);
        int berr = 0;
        n = 1;
        while (!bus.done && n < 30) begin
            if (bus.busy !== 1'b1) berr++;
            tick();
            n++;
        end
        check({name, " busy_run"}, berr, 0);
        check({name, " busy_at_done"}, bus.busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        launch(v.kl, v.ct);
        wait_done(v.name, n);
        check({v.name, " latency"}, n, 11);
        check({v.name, " pt"}, bus.pt, v.pt);
        tick();
        check({v.name, " done_pulse"}, bus.done, 0);
        check({v.name, " pt_hold"}, bus.pt, v.pt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dcnt;
        logic [0:127] k, p, c, kl;
        for (int x = 0; x < 256; x++) sbox_t[x] = sb_calc(x);
        bus.start = 1'b0;
        bus.ct = '0;
        bus.key_last = '0;
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'($urandom);
            bus.ct = rand128();
            bus.key_last = rand128();
            tick();
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_pt", bus.pt, 0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_pt", bus.pt, 0);

        vecs.push_back('{"fips_b", KB, CB, PB});
        vecs.push_back('{"fips_c1", KC, CC, PC});
        for (int i = 0; i < 8; i++) begin
            k = rand128();
            p = rand128();
            encrypt(k, p, c, kl);
            vecs.push_back('{$sformatf("rand%0d", i), kl, c, p});
        end
        foreach (vecs[i]) run_vec(vecs[i]);

        launch(KB, CB);
        wait_done("b2b_first", n);
        check("b2b_first latency", n, 11);
        check("b2b_first pt", bus.pt, PB);
        launch(KC, CC);
        wait_done("b2b_second", n);
        check("b2b_second latency", n, 11);
        check("b2b_second pt", bus.pt, PC);
        tick();

        launch(KB, CB);
        n = 1;
        while (!bus.done && n < 30) begin
            bus.start = (n == 3 || n == 7);
            if (bus.start) bus.ct = CC;
            if (n == 5) check("ign pt_stable", bus.pt, PC);
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("ign latency", n, 11);
        check("ign pt", bus.pt, PB);
        dcnt = 0;
        repeat (15) begin
            tick();
            if (bus.done) dcnt++;
        end
        check("ign extra_done", dcnt, 0);

        launch(KC, CC);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort pt", bus.pt, 0);
        tick();
        tick();
        rst = 1'b0;
        dcnt = 0;
        repeat (15) begin
            tick();
            if (bus.done) dcnt++;
        end
        check("abort no_done", dcnt, 0);
        check("abort pt_after", bus.pt, 0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
